stepdir_gen: RTL
================

Name: stepdir_gen

Overview:
- Position-tracking step/direction generator. It is the transmit side of the counter block's trigger_i/dir_i interface.
- It compares a 32-bit target position with an internal position and emits single-cycle trig_o pulses with dir_o. A downstream counter with STEP=1 and the same START therefore reproduces the target.
- Step rate is limited by the PERIOD register.
- Sits on the position bus next to counter; outputs go to the bit bus.

Parameters:
POS_W, 32, position/START width
PER_W, 32, PERIOD width

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
enable_i  in  1  block enable from bit bus
target_i  in  POS_W  target position from position bus
START  in  POS_W  initial position register
START_WSTB  in  1  write strobe for START, one cycle
PERIOD  in  PER_W  clocks per step
PERIOD_WSTB  in  1  write strobe for PERIOD, one cycle
trig_o  out  1  step pulse, counter trigger
dir_o  out  1  direction: 0 = up, 1 = down (counter convention)
pos_o  out  POS_W  internal tracked position
busy_o  out  1  step in progress

Behaviour:
- One clock is used. Reset is synchronous and active-high.
- Reset: state IDLE, trig_o=0, dir_o=0, pos_o=0, busy_o=0, wait counter 0.
- Effective period: P = max(PERIOD, 3), sampled on entry to WAIT. PERIOD_WSTB has no other effect.
- Difference: d = target_i - pos_o, computed modulo 2^32 and read as signed.
  - d>0: step up.
  - d<0: step down.
  - d=0x80000000: step down.
  - Wrap always takes the shortest signed path.
- FSM:
  - IDLE: if enable_i=1 and d!=0, go to SETUP.
  - SETUP: dir_o <= (d<0). Held for 1 cycle, so dir is stable one cycle before trig. Go to PULSE.
  - PULSE: trig_o=1 for exactly 1 cycle. At the end of the cycle, pos_o <= pos_o ±1 (modular wrap). Go to WAIT with count P-2.
  - WAIT: trig_o=0. Decrement the count. At count 1:
    - if enable_i=1 and d!=0 (d from updated pos_o), go to SETUP;
    - otherwise go to IDLE.
  - Continuous stepping therefore gives trig_o rising edges exactly P clocks apart.
- dir_o is held between steps and changes only in SETUP.
- trig_o is registered, low in every state except PULSE.
- busy_o=1 in SETUP, PULSE and WAIT.
- pos_o latency: updates 1 cycle after trig_o rises, matching the counter output latency.
- enable_i rising edge (registered compare): pos_o <= START, FSM forced to IDLE. This mirrors the counter's load-on-enable.
- enable_i falling mid-step: the current SETUP→PULSE→WAIT sequence completes, then IDLE. No new step starts while enable_i=0.
- START_WSTB: pos_o <= START, FSM forced to IDLE, trig_o=0 next cycle. This is accepted in any state and takes priority over the PULSE position update and over the enable edge in the same cycle.
- target_i changes in any state: only the next IDLE/WAIT decision uses the new value. There is no abort.
- reset_i mid-operation: full reset values next cycle. Takes priority over everything.

Decomposition:
- Shared package stepdir_pkg holds:
  - FSM state enum {IDLE, SETUP, PULSE, WAIT};
  - constant MIN_PERIOD = 3;
  - constants DIR_UP = 0, DIR_DOWN = 1 (shared with counter).
- One sub-module: stepdir_timer, the PERIOD clamp plus down-counter with load/expire. Everything else stays in the top module.

Test Plan:
- Reset held 5 cycles, all inputs driven → trig_o=0, dir_o=0, pos_o=0, busy_o=0 throughout.
- START=0, enable rise, PERIOD=5, target=3 → 3 trig pulses with rising edges 5 clocks apart; dir_o=0; pos_o ends at 3; busy_o falls after the final WAIT.
- From pos 3, target=-2 (0xFFFFFFFE) → dir_o=1 one cycle before the first pulse, 5 pulses, pos_o=0xFFFFFFFE. A counter UUT looped back with STEP=1 shows the same out every cycle.
- PERIOD=0, target=4 from 0 → pulses 3 clocks apart (clamped), 4 pulses.
- START=0x7FFFFFFE, enable rise, target=0x80000001 → 3 up-steps with dir_o=0 and pos_o=0x80000001. It must not take the long path down.
- START_WSTB with START=10 during WAIT of a sequence toward target=100 → pos_o=10 next cycle, no trig that cycle, stepping resumes up from 10. Separately, enable_i dropped during PULSE → that step completes (pos_o +1) and no further pulses occur.

Source files
------------

// File: rtl/stepdir_pkg.sv
// rtl/stepdir_pkg.sv - shared types and constants for the step/direction generator
package stepdir_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_e;

  localparam int unsigned MIN_PERIOD = 3;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/stepdir_if.sv
// rtl/stepdir_if.sv - register, position and bit-bus signals of the step/direction generator
interface stepdir_if #(
  parameter int POS_W = 32,
  parameter int PER_W = 32
);
  logic             enable_i;
  logic [POS_W-1:0] target_i;
  logic [POS_W-1:0] START;
  logic             START_WSTB;
  logic [PER_W-1:0] PERIOD;
  logic             PERIOD_WSTB;
  logic             trig_o;
  logic             dir_o;
  logic [POS_W-1:0] pos_o;
  logic             busy_o;

  modport master (
    output enable_i, target_i, START, START_WSTB, PERIOD, PERIOD_WSTB,
    input  trig_o, dir_o, pos_o, busy_o
  );

  modport slave (
    input  enable_i, target_i, START, START_WSTB, PERIOD, PERIOD_WSTB,
    output trig_o, dir_o, pos_o, busy_o
  );
endinterface

// File: rtl/stepdir_timer.sv
// rtl/stepdir_timer.sv - clamped step period down-counter with load and expire
module stepdir_timer
  import stepdir_pkg::*;
#(
  parameter int PER_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             load_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [PER_W-1:0] cnt_q, cnt_d, per_eff;

  // SETUP and PULSE take two of the P clocks, so the wait phase lasts P-2
  assign per_eff = (period_i < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : period_i;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = per_eff - PER_W'(2);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - PER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == PER_W'(1));

endmodule

// File: rtl/stepdir_gen.sv
// rtl/stepdir_gen.sv - position-tracking step/direction generator driving a counter trigger
module stepdir_gen
  import stepdir_pkg::*;
#(
  parameter int POS_W = 32,
  parameter int PER_W = 32
) (
  input  logic      clk_i,
  input  logic      reset_i,
  stepdir_if.slave  bus
);

  state_e           state_q;
  logic             trig_q, dir_q, busy_q, en_q;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] diff_d, pos_d;
  logic             dir_d, step_d, force_d, expired;

  // Modular difference read as signed: MSB set means the short path is downward
  assign diff_d  = bus.target_i - pos_q;
  assign dir_d   = diff_d[POS_W-1] ? DIR_DOWN : DIR_UP;
  assign step_d  = bus.enable_i && (diff_d != '0);
  assign pos_d   = (dir_q == DIR_DOWN) ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
  assign force_d = bus.START_WSTB || (bus.enable_i && !en_q);

  stepdir_timer #(.PER_W(PER_W)) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .period_i  (bus.PERIOD),
    .load_i    ((state_q == PULSE) && !force_d),
    .dec_i     (state_q == WAIT),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      dir_q   <= DIR_UP;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      pos_q   <= '0;
    end else begin
      en_q   <= bus.enable_i;
      trig_q <= 1'b0;
      if (force_d) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        pos_q   <= bus.START;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (step_d) begin
              state_q <= SETUP;
              dir_q   <= dir_d;
              busy_q  <= 1'b1;
            end
          end
          SETUP: begin
            state_q <= PULSE;
            trig_q  <= 1'b1;
          end
          PULSE: begin
            state_q <= WAIT;
            pos_q   <= pos_d;
          end
          WAIT: begin
            if (expired) begin
              if (step_d) begin
                state_q <= SETUP;
                dir_q   <= dir_d;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.trig_o = trig_q;
  assign bus.dir_o  = dir_q;
  assign bus.pos_o  = pos_q;
  assign bus.busy_o = busy_q;

endmodule
